// File: rtl/shift_mix_stage.sv
// AES round stage: ShiftRows on capture, then MixColumns (column-serial, or all four
// columns in one cycle when MIXCOL_PARALLEL_EN is defined), with valid/ready handshake.
module shift_mix_stage #(
  parameter logic [127:0] RESET_DATA = 128'h0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic         last_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state;
  logic [1:0]   col;
  logic         lr_q;
  logic [127:0] work;
  logic [127:0] mixed;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  // Output byte (4c+r) takes input byte (4*((c+r) mod 4) + r).
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

`ifdef MIXCOL_PARALLEL_EN
  always_comb begin
    mixed = work;
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = mix_col(work[127-32*c -: 32]);
    end
  end
`else
  logic [31:0] col_in;
  logic [31:0] col_out;

  // One shared mixer: select the current column, mix it, write it back in place.
  always_comb begin
    case (col)
      2'd0:    col_in = work[127:96];
      2'd1:    col_in = work[95:64];
      2'd2:    col_in = work[63:32];
      default: col_in = work[31:0];
    endcase
    col_out = mix_col(col_in);
    mixed   = work;
    case (col)
      2'd0:    mixed[127:96] = col_out;
      2'd1:    mixed[95:64]  = col_out;
      2'd2:    mixed[63:32]  = col_out;
      default: mixed[31:0]   = col_out;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      col       <= 2'd0;
      lr_q      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      work      <= RESET_DATA;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= shift_rows(data_in);
            lr_q     <= last_round;
            col      <= 2'd0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (!lr_q) work <= mixed;
`ifdef MIXCOL_PARALLEL_EN
          state     <= DONE;
          out_valid <= 1'b1;
`else
          col <= col + 2'd1;
          if (col == 2'd3) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign data_out = work;

endmodule

// File: tb/tb_shift_mix_stage.sv
// Directed bench for shift_mix_stage: FIPS-197 vectors, column vectors, backpressure,
// mid-operation reset and back-to-back streaming.
module tb_shift_mix_stage;

`ifdef MIXCOL_PARALLEL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 4;
`endif

  localparam logic [127:0] V1  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] E1  = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] E1L = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] C1  = {4{32'hdb135345}};
  localparam logic [127:0] C1E = {4{32'h8e4da1bc}};
  localparam logic [127:0] C2  = {4{32'hc6c6c6c6}};
  localparam logic [127:0] C3  = {4{32'h2d26314c}};
  localparam logic [127:0] C3E = {4{32'h4d7ebdf8}};

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         last_round;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;

  int errors = 0;
  int checks = 0;

  shift_mix_stage dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
    .last_round (last_round),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one block, measure latency, check the result, then drain it.
  task automatic send(input logic [127:0] d, input logic lr, input logic [127:0] exp,
                      input string tag);
    int n;
    in_valid   = 1'b1;
    data_in    = d;
    last_round = lr;
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 128'(n), 128'(LAT));
    chk({tag, "_data"}, data_out, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drain_ov"}, 128'(out_valid), 128'(0));
    chk({tag, "_drain_ir"}, 128'(in_ready), 128'(1));
  endtask

  logic [127:0] bv [3];
  logic [127:0] be [3];
  int idx;
  int ocnt;
  int n;
  logic acc;

  initial begin
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    data_in    = '0;
    last_round = 1'b0;
    out_ready  = 1'b0;
    #3;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_data_out", data_out, 128'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));

    send(V1, 1'b0, E1, "rnd1");
    send(V1, 1'b1, E1L, "last_round");
    send(C1, 1'b0, C1E, "col_db13");
    send(C2, 1'b0, C2, "col_c6");
    send(C3, 1'b0, C3E, "col_2d26");

    // Backpressure: hold DONE for 10 clocks while in_valid toggles with other data.
    in_valid = 1'b1;
    data_in  = V1;
    last_round = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_reach_done", 128'(out_valid), 128'(1));
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      data_in  = ~V1;
      @(posedge clk); #1;
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_data_out", data_out, E1);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_ov", 128'(out_valid), 128'(0));
    chk("bp_release_ir", 128'(in_ready), 128'(1));

    // Reset asserted mid-operation.
    in_valid = 1'b1;
    data_in  = C1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_data_out", data_out, 128'h0);
    #10 reset_n = 1'b1;
    #1;
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_ov_after", 128'(out_valid), 128'(0));
    @(posedge clk); #1;
    send(V1, 1'b0, E1, "after_rst");

    // Back-to-back streaming with in_valid held high.
    bv[0] = V1; be[0] = E1;
    bv[1] = C1; be[1] = C1E;
    bv[2] = C3; be[2] = C3E;
    idx = 0;
    ocnt = 0;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    last_round = 1'b0;
    data_in    = bv[0];
    for (int cyc = 0; cyc < 200 && ocnt < 3; cyc++) begin
      acc = in_ready && in_valid;
      if (out_valid) begin
        chk("b2b_data", data_out, be[ocnt]);
        ocnt++;
      end
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 3) data_in = bv[idx];
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("b2b_out_count", 128'(ocnt), 128'(3));
    chk("b2b_accept_count", 128'(idx), 128'(3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
